// File: rtl/out_port_buffer_pkg.sv
// Shared router constants and helpers, also used by the port arbiter.
package router_pkg;

  localparam int NUM_PORTS  = 4;
  localparam int PORT_IDX_W = $clog2(NUM_PORTS);
  localparam int FLIT_W     = 32;

  typedef logic [FLIT_W-1:0]     flit_t;
  typedef logic [PORT_IDX_W-1:0] port_idx_t;

  function automatic logic is_onehot(input logic [NUM_PORTS-1:0] vec);
    return (vec != {NUM_PORTS{1'b0}}) &&
           ((vec & (vec - {{(NUM_PORTS-1){1'b0}}, 1'b1})) == {NUM_PORTS{1'b0}});
  endfunction

  // Only meaningful for one-hot input; returns the index of the highest set bit.
  function automatic port_idx_t onehot2idx(input logic [NUM_PORTS-1:0] vec);
    port_idx_t idx;
    idx = {PORT_IDX_W{1'b0}};
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (vec[k]) begin
        idx = port_idx_t'(k);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/out_port_buffer_if.sv
// Arbiter-side and link-side signals of the output port buffer.
interface out_port_buffer_if
  import router_pkg::*;
#(
  parameter int FLIT_W = 32
);
  logic [NUM_PORTS-1:0]             grant_i;
  logic                             grant_v_i;
  logic [NUM_PORTS-1:0][FLIT_W-1:0] flit_i;
  logic                             buffer_full_o;
  logic [FLIT_W-1:0]                flit_o;
  logic                             valid_o;
  logic                             credit_i;
  logic                             err_o;

  modport master (
    output grant_i, grant_v_i, flit_i, credit_i,
    input  buffer_full_o, flit_o, valid_o, err_o
  );

  modport slave (
    input  grant_i, grant_v_i, flit_i, credit_i,
    output buffer_full_o, flit_o, valid_o, err_o
  );
endinterface

// File: rtl/out_port_buffer_credit_counter.sv
// Saturating downstream credit counter with overflow detection.
module credit_counter #(
  parameter int CREDITS = 4
)(
  input  logic clk,
  input  logic rst,
  input  logic dec_i,
  input  logic inc_i,
  output logic avail_o,
  output logic ovf_o
);
  localparam int CNT_W = $clog2(CREDITS + 1);

  logic [CNT_W-1:0] credits_r;
  logic             at_max_s;

  assign at_max_s = (credits_r == CNT_W'(CREDITS));
  assign avail_o  = (credits_r != {CNT_W{1'b0}});
  // A return without a concurrent spend at the ceiling is a downstream protocol error.
  assign ovf_o    = inc_i && !dec_i && at_max_s;

  // Credit count: spend on send, return on credit pulse, both cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      credits_r <= CNT_W'(CREDITS);
    end else begin
      case ({inc_i, dec_i})
        2'b10:   credits_r <= at_max_s ? credits_r : credits_r + CNT_W'(1'b1);
        2'b01:   credits_r <= avail_o ? credits_r - CNT_W'(1'b1) : credits_r;
        default: credits_r <= credits_r;
      endcase
    end
  end
endmodule

// File: rtl/register.sv
// Enabled register with synchronous clear; used as a FIFO storage entry.
module register #(
  parameter int W = 32
)(
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  // Entry storage: cleared on reset, loaded when enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_o <= {W{1'b0}};
    end else if (en_i) begin
      q_o <= d_i;
    end
  end
endmodule

// File: rtl/out_port_buffer.sv
// Output port buffer: muxes the granted input flit into a FIFO and drains it
// onto the outbound link under credit-based flow control.
module out_port_buffer
  import router_pkg::*;
#(
  parameter int FLIT_W  = 32,
  parameter int DEPTH   = 4,
  parameter int CREDITS = 4
)(
  input  logic             clk,
  input  logic             rst,
  out_port_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              err_r;
  logic              full_s;
  logic              wr_en_s;
  logic              reject_s;
  logic              send_s;
  logic              avail_s;
  logic              ovf_s;
  logic [FLIT_W-1:0] sel_flit_s;
  logic [DEPTH-1:0]  entry_en_s;
  logic [FLIT_W-1:0] mem_s [DEPTH];

  // Full comes from registered count only, so the arbiter sees no loop through us.
  assign full_s     = (count_r == CNT_W'(DEPTH));
  assign wr_en_s    = bus.grant_v_i && !full_s && is_onehot(bus.grant_i);
  assign reject_s   = bus.grant_v_i && !wr_en_s;
  assign send_s     = (count_r != {CNT_W{1'b0}}) && avail_s;
  assign sel_flit_s = bus.flit_i[onehot2idx(bus.grant_i)];

  genvar e;
  generate
    for (e = 0; e < DEPTH; e++) begin : g_entry
      assign entry_en_s[e] = wr_en_s && (wr_ptr_r == PTR_W'(e));
      register #(.W(FLIT_W)) u_entry (
        .clk  (clk),
        .rst  (rst),
        .en_i (entry_en_s[e]),
        .d_i  (sel_flit_s),
        .q_o  (mem_s[e])
      );
    end
  endgenerate

  credit_counter #(.CREDITS(CREDITS)) u_credit (
    .clk     (clk),
    .rst     (rst),
    .dec_i   (send_s),
    .inc_i   (bus.credit_i),
    .avail_o (avail_s),
    .ovf_o   (ovf_s)
  );

  // FIFO pointers, occupancy and the sticky protocol-error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      err_r    <= 1'b0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (send_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      case ({wr_en_s, send_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
      if (reject_s || ovf_s) begin
        err_r <= 1'b1;
      end
    end
  end

  assign bus.buffer_full_o = full_s;
  assign bus.valid_o       = send_s;
  assign bus.flit_o        = mem_s[rd_ptr_r];
  assign bus.err_o         = err_r;
endmodule

// File: tb/tb_out_port_buffer.sv
// Directed self-checking bench for out_port_buffer (DEPTH=4, CREDITS=4).
module tb_out_port_buffer;
  import router_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  out_port_buffer_if #(.FLIT_W(32)) bus_if ();

  out_port_buffer #(.FLIT_W(32), .DEPTH(4), .CREDITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ports(input flit_t base, input flit_t step);
    for (int k = 0; k < NUM_PORTS; k++) begin
      bus_if.flit_i[k] = base + flit_t'(k) * step;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    flit_t exp_f;
    bus_if.grant_i   = 4'b0000;
    bus_if.grant_v_i = 1'b0;
    bus_if.credit_i  = 1'b0;
    set_ports(32'h0, 32'h0);
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_full",    bus_if.buffer_full_o, 1'b0);
    chk("rst_valid",   bus_if.valid_o, 1'b0);
    chk("rst_err",     bus_if.err_o, 1'b0);
    chk("rst_flit",    bus_if.flit_o, 32'h0);
    chk("rst_credits", dut.u_credit.credits_r, 3'd4);

    // Fill and drain with full credits: each flit leaves the cycle after its write
    set_ports(32'hA0, 32'h1);
    bus_if.grant_v_i = 1'b1;
    for (int j = 0; j < 4; j++) begin
      bus_if.grant_i = 4'b0001 << j;
      tick();
      chk("fd_valid", bus_if.valid_o, 1'b1);
      chk("fd_flit",  bus_if.flit_o, 32'hA0 + 32'(j));
      chk("fd_count", dut.count_r, 3'd1);
    end
    bus_if.grant_v_i = 1'b0;
    tick();
    chk("fd_drained_valid", bus_if.valid_o, 1'b0);
    chk("fd_credits_zero",  dut.u_credit.credits_r, 3'd0);

    // No credits: four writes fill the FIFO, nothing departs
    set_ports(32'hB0, 32'h100);
    bus_if.grant_v_i = 1'b1;
    for (int j = 0; j < 4; j++) begin
      bus_if.grant_i = 4'b0001 << j;
      tick();
      chk("fill_full",  bus_if.buffer_full_o, (j == 3) ? 1'b1 : 1'b0);
      chk("fill_valid", bus_if.valid_o, 1'b0);
    end
    chk("fill_head", bus_if.flit_o, 32'hB0);

    // Write to full is dropped and flags an error
    bus_if.grant_i   = 4'b0100;
    bus_if.flit_i[2] = 32'hDEAD;
    tick();
    bus_if.grant_v_i = 1'b0;
    chk("wfull_err",   bus_if.err_o, 1'b1);
    chk("wfull_count", dut.count_r, 3'd4);
    chk("wfull_head",  bus_if.flit_o, 32'hB0);

    // Credit stall: one pulse releases exactly one flit
    bus_if.credit_i = 1'b1;
    tick();
    bus_if.credit_i = 1'b0;
    chk("cs_valid", bus_if.valid_o, 1'b1);
    chk("cs_flit",  bus_if.flit_o, 32'hB0);
    tick();
    chk("cs_after_valid", bus_if.valid_o, 1'b0);
    chk("cs_after_count", dut.count_r, 3'd3);
    chk("cs_after_full",  bus_if.buffer_full_o, 1'b0);
    chk("cs_after_head",  bus_if.flit_o, 32'h1B0);

    // Drain the rest: contents untouched by the rejected write
    bus_if.credit_i = 1'b1;
    for (int j = 1; j < 4; j++) begin
      tick();
      chk("drain_valid", bus_if.valid_o, 1'b1);
      chk("drain_flit",  bus_if.flit_o, 32'hB0 + 32'(j) * 32'h100);
    end
    bus_if.credit_i = 1'b0;
    tick();
    chk("drain_empty", dut.count_r, 3'd0);
    chk("drain_err_sticky", bus_if.err_o, 1'b1);

    // Bad grants: multiple bits, then zero bits
    do_reset();
    chk("bg_err_cleared", bus_if.err_o, 1'b0);
    bus_if.grant_v_i = 1'b1;
    bus_if.grant_i   = 4'b0110;
    tick();
    bus_if.grant_v_i = 1'b0;
    chk("bg_multi_err",   bus_if.err_o, 1'b1);
    chk("bg_multi_count", dut.count_r, 3'd0);
    do_reset();
    bus_if.grant_v_i = 1'b1;
    bus_if.grant_i   = 4'b0000;
    tick();
    bus_if.grant_v_i = 1'b0;
    chk("bg_zero_err",   bus_if.err_o, 1'b1);
    chk("bg_zero_count", dut.count_r, 3'd0);

    // Credit overflow saturates and flags an error
    do_reset();
    bus_if.credit_i = 1'b1;
    tick();
    bus_if.credit_i = 1'b0;
    chk("ovf_err",     bus_if.err_o, 1'b1);
    chk("ovf_credits", dut.u_credit.credits_r, 3'd4);

    // Stream 12 flits across pointer wrap, credits returned from the third cycle
    do_reset();
    bus_if.grant_v_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      set_ports(32'hC000_0000 + 32'(i), 32'h100);
      bus_if.grant_i  = 4'b0001 << (i % 4);
      bus_if.credit_i = (i >= 2) ? 1'b1 : 1'b0;
      tick();
      exp_f = 32'hC000_0000 + 32'(i) + 32'(i % 4) * 32'h100;
      chk("st_flit",    bus_if.flit_o, exp_f);
      chk("st_valid",   bus_if.valid_o, 1'b1);
      chk("st_count",   dut.count_r, 3'd1);
      chk("st_credits", dut.u_credit.credits_r, (i == 0) ? 3'd4 : 3'd3);
    end
    bus_if.grant_v_i = 1'b0;
    bus_if.credit_i  = 1'b0;
    tick();
    chk("st_end_valid", bus_if.valid_o, 1'b0);
    chk("st_end_err",   bus_if.err_o, 1'b0);

    // Reset mid-stream: exhaust credits, queue 3 flits, set err, then reset
    do_reset();
    set_ports(32'hE0, 32'h1);
    bus_if.grant_v_i = 1'b1;
    bus_if.grant_i   = 4'b0001;
    for (int j = 0; j < 7; j++) begin
      tick();
    end
    bus_if.grant_i = 4'b0000;
    tick();
    bus_if.grant_v_i = 1'b0;
    chk("rm_pre_count", dut.count_r, 3'd3);
    chk("rm_pre_err",   bus_if.err_o, 1'b1);
    chk("rm_pre_valid", bus_if.valid_o, 1'b0);
    rst              = 1'b1;
    bus_if.credit_i  = 1'b1;
    bus_if.grant_v_i = 1'b1;
    bus_if.grant_i   = 4'b0010;
    tick();
    rst              = 1'b0;
    bus_if.credit_i  = 1'b0;
    bus_if.grant_v_i = 1'b0;
    chk("rm_valid",   bus_if.valid_o, 1'b0);
    chk("rm_full",    bus_if.buffer_full_o, 1'b0);
    chk("rm_err",     bus_if.err_o, 1'b0);
    chk("rm_credits", dut.u_credit.credits_r, 3'd4);
    chk("rm_count",   dut.count_r, 3'd0);
    chk("rm_flit",    bus_if.flit_o, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
